mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the shared, byte-addressed, little-endian MIPS data memory (`DataMem`). It shares that single memory between the instruction-fetch port and the load/store port. Each granted access is sequenced as a fixed-latency read or byte-enabled write, and completion is returned with a one-cycle ack. It sits between the pipeline's fetch/MEM stages and the memory array; the pipeline stalls on a port until its ack.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `MEM_LAT`, 2, memory access cycles (read or write strobe held this long), legal 1..15
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch byte address; bits [1:0] ignored
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  32  fetched word, valid with `if_ack`, held until next fetch completes
- `d_req`  in  1  load/store request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  4  byte enables for stores (bit n = byte lane n)
- `d_addr`  in  ADDR_W  data byte address; bits [1:0] ignored
- `d_wdata`  in  32  store data, lane-aligned
- `d_ack`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  32  loaded word, valid with `d_ack`, held until next load completes
- `mem_addr`  out  ADDR_W  word-aligned address to memory, `{addr[ADDR_W-1:2],2'b00}`
- `mem_wdata`  out  32  write data to memory
- `mem_be`  out  4  byte-lane write enables to memory
- `mem_read`  out  1  read strobe
- `mem_write`  out  1  write strobe
- `mem_rdata`  in  32  read data from memory, valid in the last strobe cycle
- `busy`  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high at the clock edge, select a winner. Latch its address, we, be and wdata into internal registers. Load the latency counter with `MEM_LAT-1` and go to ACCESS. With no requests, stay in IDLE.
- ACCESS: drive `mem_read` (load or fetch) or `mem_write` (store) plus the latched addr/be/wdata. Decrement the counter each cycle. When the counter is 0, capture `mem_rdata` into the winner's rdata register (reads only) and go to DONE.
- DONE: pulse the winner's ack for one cycle, then go to IDLE. Requests are not sampled in DONE.
- Fetch accesses always use be = 4'b1111 and are read-only.
- A store with `d_be` = 0 still runs the full sequence and is acked, but `mem_write` stays low throughout.
- Requester inputs are sampled only in IDLE. Changes during ACCESS/DONE have no effect. If a req drops mid-access, the access still completes and the ack still pulses.
- Default priority: on simultaneous requests, data wins over fetch.

## Timing
- Reset (`rst_n`=0 at an edge) puts the FSM in IDLE. Reset values: `if_ack`=0, `d_ack`=0, `mem_read`=0, `mem_write`=0, `busy`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `if_rdata`=0, `d_rdata`=0.
- Reset mid-access: strobes drop at the reset edge and no ack is issued. The aborted access is lost; the requester must re-request.
- If a req is sampled in IDLE at edge t, strobes are high in cycles t+1 .. t+MEM_LAT and the ack is high in cycle t+MEM_LAT+1.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- All outputs are registered. The strobes are deasserted in DONE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on simultaneous requests. A last-granted flag records the last port served, and the other port wins the tie. Reset sets the flag to "fetch", so data wins the first tie.
- Not defined: fixed data-over-fetch priority. No last-granted flag is implemented.

## Test plan
- Reset, then MEM_LAT=2, `d_req` load at `d_addr`=0x10 with memory word 0xDEADBEEF. Expect `mem_read` high for 2 cycles, `d_ack` in the 3rd cycle after the sample, and `d_rdata`=0xDEADBEEF.
- Store `d_be`=4'b0011, `d_wdata`=0x0000BEEF at 0x22. Expect `mem_addr`=0x20, `mem_be`=0011, and `mem_write` high for 2 cycles. A subsequent load of 0x20 returns the upper half unchanged and the lower half 0xBEEF.
- `if_req` and `d_req` asserted together and held. Without the macro, the grant order is D, D, D… while `d_req` stays high. With `MEM_ARB_RR_EN`, the order alternates D, I, D, I, with acks every 4 cycles.
- Store with `d_be`=0. Expect `d_ack` after 3 cycles, `mem_write` never high, and memory unchanged.
- `rst_n` low for one cycle during ACCESS of a fetch. Expect strobes 0 at the next edge, no `if_ack`, and the FSM in IDLE. A re-requested fetch then completes normally.
- `if_addr`=0x1007. Expect `mem_addr`=0x1004, `mem_be`=1111, and `if_rdata` = the word at 0x1004.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared MIPS data memory (fetch vs. load/store).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats fetch.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester raises req with stable payload and holds it until
    // its ack pulses for one cycle; payload is only sampled while IDLE.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       sel_d;
    logic       lat_we;
    logic       grant_any;
    logic       grant_d;
    logic       rd_nx, wr_nx, if_ack_nx, d_ack_nx, busy_nx;
    logic       unused_ok;

    assign unused_ok = ^{if_addr[1:0], d_addr[1:0]};
    assign state_dbg = state;
    assign grant_any = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    logic last_d;  // 1 = data was the last port served
    assign grant_d = d_req & (~if_req | ~last_d);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered control outputs, one cycle ahead of the state.
    always_comb begin
        rd_nx     = 1'b0;
        wr_nx     = 1'b0;
        if_ack_nx = 1'b0;
        d_ack_nx  = 1'b0;
        busy_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    busy_nx = 1'b1;
                    if (grant_d) begin
                        rd_nx = ~d_we;
                        wr_nx = d_we & (|d_be);
                    end else begin
                        rd_nx = 1'b1;
                    end
                end
            end
            ACCESS: begin
                busy_nx = 1'b1;
                if (cnt != 4'd0) begin
                    rd_nx = mem_read;
                    wr_nx = mem_write;
                end else begin
                    if_ack_nx = ~sel_d;
                    d_ack_nx  = sel_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            cnt       <= '0;
            sel_d     <= 1'b0;
            lat_we    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            mem_read  <= rd_nx;
            mem_write <= wr_nx;
            if_ack    <= if_ack_nx;
            d_ack     <= d_ack_nx;
            busy      <= busy_nx;
            if (state == IDLE && grant_any) begin
                sel_d  <= grant_d;
                lat_we <= grant_d & d_we;
                cnt    <= LAT_M1;
`ifdef MEM_ARB_RR_EN
                last_d <= grant_d;
`endif
                if (grant_d) begin
                    mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                    mem_be    <= d_be;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                    mem_be    <= 4'b1111;
                    mem_wdata <= '0;
                end
            end else if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!lat_we) begin
                    if (sel_d) d_rdata  <= mem_rdata;
                    else       if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, driver tasks and an ack scoreboard.
// Tie-break expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk, rst_n;
    logic              if_req, if_ack, d_req, d_we, d_ack;
    logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
    logic [31:0]       if_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [3:0]        d_be, mem_be;
    logic              mem_read, mem_write, busy;
    logic [1:0]        state_dbg;

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset-sample block
    int   cyc = 0;
    logic rst_q = 1'b0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // memory model: read data valid whenever the read strobe is high
    logic [31:0] mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    assign mem_rdata = mem_read ? mem[mem_addr[12:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0101_0101 * i;
        mem[11'h004] = 32'hDEAD_BEEF;
        mem[11'h008] = 32'h1234_5678;
        mem[11'h401] = 32'hCAFE_F00D;
        forever begin
            @(posedge clk);
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[12:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard entry: {port(1=data), kind(0 read,1 write,2 no-strobe store), chk_data, data}
    logic [35:0] exp_q[$];

    task automatic push_exp(input bit is_d, input logic [1:0] kind, input bit chk,
                            input logic [31:0] data);
        exp_q.push_back({is_d, kind, chk, data});
    endtask

    // monitor: counts strobe cycles per access and checks every ack against the queue
    int rd_cnt = 0;
    int wr_cnt = 0;
    initial begin
        logic [35:0] e;
        logic        prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                rd_cnt   = 0;
                wr_cnt   = 0;
                prev_ack = 1'b0;
            end else begin
                if (mem_read)  rd_cnt++;
                if (mem_write) wr_cnt++;
                if (if_ack && d_ack) check("dual_ack", 32'd1, 32'd0);
                if (prev_ack && (if_ack || d_ack)) check("ack_width", 32'd2, 32'd1);
                if (if_ack || d_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_port", 32'(d_ack), 32'(e[35]));
                        check("rd_cycles", 32'(rd_cnt), (e[34:33] == 2'd0) ? 32'(MEM_LAT) : 32'd0);
                        check("wr_cycles", 32'(wr_cnt), (e[34:33] == 2'd1) ? 32'(MEM_LAT) : 32'd0);
                        if (e[32]) check("rdata", d_ack ? d_rdata : if_rdata, e[31:0]);
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
                prev_ack = if_ack | d_ack;
            end
        end
    end

    // driver: one access on one port, DUT assumed idle; called at a negedge
    task automatic issue(input bit is_d, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int idx;
        int lat;
        idx = int'(addr[12:2]);
        if (is_d && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            push_exp(1'b1, (be != 4'd0) ? 2'd1 : 2'd2, 1'b0, 32'h0);
        end else begin
            push_exp(is_d, 2'd0, 1'b1, ref_mem[idx]);
        end
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                if (!is_d || we) check("mem_be", 32'(mem_be), is_d ? 32'(be) : 32'hF);
            end
            if (is_d ? d_ack : if_ack) begin
                lat = k;
                break;
            end
        end
        check("ack_latency", 32'(lat), 32'(MEM_LAT + 1));
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
        @(negedge clk);
    endtask

    // both ports held together; each request is dropped once its quota of acks is seen
    task automatic tie_test(input int d_quota, input int i_quota);
        int d_rem, i_rem, n_ack, last_cyc;
        d_rem = d_quota;
        i_rem = i_quota;
        n_ack = 0;
        last_cyc = 0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h1004;
        for (int k = 0; k < 60 && (d_rem + i_rem) > 0; k++) begin
            @(negedge clk);
            if (d_ack || if_ack) begin
                if (n_ack > 0) check("ack_spacing", 32'(cyc - last_cyc), 32'(MEM_LAT + 2));
                last_cyc = cyc;
                n_ack++;
                if (d_ack) begin
                    d_rem--;
                    if (d_rem == 0) d_req = 1'b0;
                end
                if (if_ack) begin
                    i_rem--;
                    if (i_rem == 0) if_req = 1'b0;
                end
            end
        end
        check("tie_ack_count", 32'(n_ack), 32'(d_quota + i_quota));
        d_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0101_0101 * i;
        ref_mem[11'h004] = 32'hDEAD_BEEF;
        ref_mem[11'h008] = 32'h1234_5678;
        ref_mem[11'h401] = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        issue(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        check("load_10", d_rdata, 32'hDEAD_BEEF);

        issue(1'b1, 1'b1, 4'b0011, 32'h22, 32'h0000_BEEF);
        issue(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        check("merge_word", d_rdata, 32'h1234_BEEF);

        issue(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
        check("be0_mem", mem[11'h004], 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);

        // reset for one cycle while a fetch is in ACCESS
        if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        check("abort_in_access", 32'(state_dbg), 32'd1);
        check("abort_strobe_on", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobe_off", 32'(mem_read), 32'd0);
        check("abort_no_ack", 32'(if_ack), 32'd0);
        check("abort_idle", 32'(state_dbg), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        if_req = 1'b0;
        repeat (5) @(negedge clk);
        issue(1'b0, 1'b0, 4'h0, 32'h20, 32'h0);
        check("refetch_20", if_rdata, 32'h1234_BEEF);

        issue(1'b0, 1'b0, 4'h0, 32'h1007, 32'h0);
        check("fetch_1004", if_rdata, 32'hCAFE_F00D);

`ifdef MEM_ARB_RR_EN
        push_exp(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF);
        push_exp(1'b0, 2'd0, 1'b1, 32'hCAFE_F00D);
        push_exp(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF);
        push_exp(1'b0, 2'd0, 1'b1, 32'hCAFE_F00D);
        tie_test(2, 2);
`else
        push_exp(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF);
        push_exp(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF);
        push_exp(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF);
        push_exp(1'b0, 2'd0, 1'b1, 32'hCAFE_F00D);
        tie_test(3, 1);
`endif

        for (int n = 0; n < 12; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 2);
            a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            if (r == 0)      issue(1'b0, 1'b0, 4'h0, a, 32'h0);
            else if (r == 1) issue(1'b1, 1'b0, 4'hF, a, 32'h0);
            else             issue(1'b1, 1'b1, 4'($urandom_range(0, 15)), a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
